// File: rtl/cla_pkg.sv
// Shared constants and a reference helper for the carry-lookahead adder slices.
package cla_pkg;

    localparam int CLA_WIDTH = 4;

    // Expected {cOut, s} for a 4-bit slice; used by benches, not by the datapath.
    function automatic logic [CLA_WIDTH:0] cla_ref(
        input logic [CLA_WIDTH-1:0] a,
        input logic [CLA_WIDTH-1:0] b,
        input logic                 cIn
    );
        return {1'b0, a} + {1'b0, b} + {{CLA_WIDTH{1'b0}}, cIn};
    endfunction

endpackage

// File: rtl/lcu.sv
// 4-bit lookahead carry unit; flattened sum-of-products carries, reusable one level up.
module lcu (
    output logic       pg,
    output logic       gg,
    output logic       cOut,
    output logic [3:1] c,
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cIn
);

    assign c[1] = g[0] | (p[0] & cIn);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cIn);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cIn);

    // Group terms exclude cIn so a parent lcu can combine slices in parallel.
    assign pg   = p[3] & p[2] & p[1] & p[0];
    assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign cOut = gg | (pg & cIn);

endmodule

// File: rtl/spg.sv
// Single-bit sum / propagate / generate cell.
module spg (
    output logic s,
    output logic p,
    output logic g,
    input  logic a,
    input  logic b,
    input  logic c
);

    assign p = a ^ b;
    assign g = a & b;
    assign s = p ^ c;

endmodule

// File: rtl/cla4_reg.sv
// 4-bit carry-lookahead adder slice with optional output register stage.
module cla4_reg
    import cla_pkg::*;
#(
    parameter bit REG_OUT = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 inValid,
    input  logic [CLA_WIDTH-1:0] a,
    input  logic [CLA_WIDTH-1:0] b,
    input  logic                 cIn,
    output logic                 outValid,
    output logic [CLA_WIDTH-1:0] s,
    output logic                 cOut,
    output logic                 pg,
    output logic                 gg
);

    logic [CLA_WIDTH-1:0] pBit;
    logic [CLA_WIDTH-1:0] gBit;
    logic [CLA_WIDTH-1:0] cBit;
    logic [CLA_WIDTH-1:0] sComb;
    logic                 cOutComb;
    logic                 pgComb;
    logic                 ggComb;

    assign cBit[0] = cIn;

    for (genvar i = 0; i < CLA_WIDTH; i++) begin : gSpg
        spg uSpg (
            .s (sComb[i]),
            .p (pBit[i]),
            .g (gBit[i]),
            .a (a[i]),
            .b (b[i]),
            .c (cBit[i])
        );
    end

    lcu uLcu (
        .pg   (pgComb),
        .gg   (ggComb),
        .cOut (cOutComb),
        .c    (cBit[3:1]),
        .p    (pBit),
        .g    (gBit),
        .cIn  (cIn)
    );

    if (REG_OUT) begin : gReg
        logic                 validQ;
        logic [CLA_WIDTH-1:0] sQ;
        logic                 cOutQ;
        logic                 pgQ;
        logic                 ggQ;

        // Data loads every cycle; only validQ qualifies it downstream.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                validQ <= 1'b0;
                sQ     <= '0;
                cOutQ  <= 1'b0;
                pgQ    <= 1'b0;
                ggQ    <= 1'b0;
            end else begin
                validQ <= inValid;
                sQ     <= sComb;
                cOutQ  <= cOutComb;
                pgQ    <= pgComb;
                ggQ    <= ggComb;
            end
        end

        assign outValid = validQ;
        assign s        = sQ;
        assign cOut     = cOutQ;
        assign pg       = pgQ;
        assign gg       = ggQ;
    end else begin : gComb
        assign outValid = inValid;
        assign s        = sComb;
        assign cOut     = cOutComb;
        assign pg       = pgComb;
        assign gg       = ggComb;
    end

endmodule

// File: tb/tb_cla4_reg.sv
// Scoreboard bench for cla4_reg: registered build via a queue/monitor, combinational build directly.
module tb_cla4_reg;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cIn;
        logic [3:0] s;
        logic       cOut;
        logic       pg;
        logic       gg;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       inValid = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       cIn = 1'b0;
    logic       outValid;
    logic [3:0] s;
    logic       cOut;
    logic       pg;
    logic       gg;

    logic       inValidC = 1'b0;
    logic [3:0] aC = '0;
    logic [3:0] bC = '0;
    logic       cInC = 1'b0;
    logic       outValidC;
    logic [3:0] sC;
    logic       cOutC;
    logic       pgC;
    logic       ggC;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    always #5 clk = ~clk;

    cla4_reg #(.REG_OUT(1'b1)) dut (
        .clk (clk), .reset_n (reset_n), .inValid (inValid),
        .a (a), .b (b), .cIn (cIn),
        .outValid (outValid), .s (s), .cOut (cOut), .pg (pg), .gg (gg)
    );

    cla4_reg #(.REG_OUT(1'b0)) dutComb (
        .clk (clk), .reset_n (reset_n), .inValid (inValidC),
        .a (aC), .b (bC), .cIn (cInC),
        .outValid (outValidC), .s (sC), .cOut (cOutC), .pg (pgC), .gg (ggC)
    );

    // Reference: plain integer addition; group flags read off the cIn-free sum.
    function automatic exp_t model(input logic [3:0] av, input logic [3:0] bv, input logic cv);
        exp_t e;
        int   sum;
        int   pair;
        pair   = int'(av) + int'(bv);
        sum    = pair + int'(cv);
        e.a    = av;
        e.b    = bv;
        e.cIn  = cv;
        e.s    = 4'(sum % 16);
        e.cOut = (sum >= 16);
        e.pg   = (pair == 15);
        e.gg   = (pair >= 16);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic checkResult(input string name, input exp_t e,
                               input logic [3:0] sv, input logic co, input logic p, input logic g);
        checks++;
        if (sv !== e.s || co !== e.cOut || p !== e.pg || g !== e.gg) begin
            errors++;
            $display("FAIL %s a=%h b=%h cIn=%b actual s/cOut/pg/gg=%h/%b/%b/%b required=%h/%b/%b/%b",
                     name, e.a, e.b, e.cIn, sv, co, p, g, e.s, e.cOut, e.pg, e.gg);
        end
    endtask

    task automatic checkZero(input string name);
        check({name, "_zero"}, {27'd0, outValid, s, cOut, pg, gg}, 0);
    endtask

    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv, input logic cv);
        @(posedge clk);
        #1;
        inValid = v;
        a       = av;
        b       = bv;
        cIn     = cv;
        if (v) expQ.push_back(model(av, bv, cv));
    endtask

    // Monitor: every valid output pops the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && outValid) begin
                if (expQ.size() == 0) begin
                    check("unexpected_outValid", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkResult("reg_result", e, s, cOut, pg, gg);
                end
            end
        end
    end

    initial begin
        int waitCycles;
        exp_t e;

        // Reset held with inputs toggling.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            inValid = 1'b1;
            a       = 4'($urandom);
            b       = 4'($urandom);
            cIn     = 1'($urandom);
            @(negedge clk);
            checkZero("reset_hold");
        end
        @(negedge clk);
        inValid = 1'b0;
        reset_n = 1'b1;

        // Directed corner vectors.
        drive(1'b1, 4'hF, 4'h1, 1'b0);
        drive(1'b1, 4'h5, 4'hA, 1'b1);
        drive(1'b1, 4'h5, 4'hA, 1'b0);
        drive(1'b1, 4'h3, 4'h4, 1'b0);
        drive(1'b1, 4'hF, 4'hF, 1'b1);

        // Exhaustive back-to-back sweep with a bubble inserted part way.
        for (int i = 0; i < 512; i++) begin
            if (i == 200) drive(1'b0, 4'h9, 4'h6, 1'b1);
            drive(1'b1, 4'(i >> 5), 4'(i >> 1), 1'(i));
        end

        // Random traffic with random bubbles.
        for (int i = 0; i < 200; i++)
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom));

        // Asynchronous reset between edges discards in-flight work.
        drive(1'b1, 4'hE, 4'h7, 1'b1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkZero("async_reset");
        expQ.delete();
        inValid = 1'b0;
        @(negedge clk);
        checkZero("async_reset_hold");
        reset_n = 1'b1;

        drive(1'b1, 4'hA, 4'h6, 1'b0);
        for (int i = 0; i < 20; i++)
            drive(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
        drive(1'b0, 4'h0, 4'h0, 1'b0);

        waitCycles = 0;
        while (expQ.size() != 0 && waitCycles < 10) begin
            @(negedge clk);
            waitCycles++;
        end
        check("queue_drained", expQ.size(), 0);
        @(negedge clk);
        check("idle_outValid", int'(outValid), 0);

        // Combinational build: full sweep, 1 ns settle each.
        for (int i = 0; i < 512; i++) begin
            aC       = 4'(i >> 5);
            bC       = 4'(i >> 1);
            cInC     = 1'(i);
            inValidC = 1'(i >> 3);
            #1;
            e = model(aC, bC, cInC);
            checkResult("comb_result", e, sC, cOutC, pgC, ggC);
            check("comb_outValid", int'(outValidC), int'(inValidC));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
